// File: rtl/host_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : host_mem_responder_if
// Description : FPGA-side and host-side request/response bundle for the
//               shared host/FPGA word memory (oob_err under HOST_MEM_OOB_CHECK_EN).
// Revision    : 1.0 - initial release
// ============================================================================
interface host_mem_responder_if;
    // FPGA side
    logic        rd_req;
    logic [20:0] req_addr;
    logic        FPGA_wr_en;
    logic [31:0] write_data;
    logic        flag_we;
    logic [31:0] out_flag;
    logic [31:0] rd_data;
    logic        rd_ready;
    logic [31:0] in_flag;
    // Host side
    logic        pci_wr_en;
    logic [20:0] pci_req_addr;
    logic [31:0] pci_input_data;
    logic        pci_start;
    logic        pci_ready;
    logic        done;
    logic [31:0] fpga_flag;
`ifdef HOST_MEM_OOB_CHECK_EN
    logic        oob_err;
`endif

    modport master (
        output rd_req, req_addr, FPGA_wr_en, write_data, flag_we, out_flag,
        output pci_wr_en, pci_req_addr, pci_input_data, pci_start,
`ifdef HOST_MEM_OOB_CHECK_EN
        input  oob_err,
`endif
        input  rd_data, rd_ready, in_flag, pci_ready, done, fpga_flag
    );

    modport slave (
        input  rd_req, req_addr, FPGA_wr_en, write_data, flag_we, out_flag,
        input  pci_wr_en, pci_req_addr, pci_input_data, pci_start,
`ifdef HOST_MEM_OOB_CHECK_EN
        output oob_err,
`endif
        output rd_data, rd_ready, in_flag, pci_ready, done, fpga_flag
    );
endinterface
`default_nettype wire

// File: rtl/host_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : host_mem_responder
// Description : Word memory shared between a host (HOST/DONE) and the FPGA
//               (RUN), with start/done handshake. Optional macro
//               HOST_MEM_OOB_CHECK_EN enables out-of-range address checking.
// Revision    : 1.0 - initial release
// ============================================================================
module host_mem_responder #(
    parameter int ADDR_W    = 12,
    parameter int START_BIT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    host_mem_responder_if.slave   bus
);

    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [1:0] S_HOST  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [31:0]       mem [DEPTH];
    logic              rd_ready_q, rd_ready_d;
    logic [31:0]       rd_data_q, rd_data_d;
    logic [31:0]       fpga_flag_q, fpga_flag_d;

    logic [ADDR_W-1:0] w_rd_idx, w_pci_idx;
    logic              w_req_hi, w_pci_hi;
    logic              w_run, w_host_own;
    logic              w_fpga_rd, w_fpga_wr, w_pci_wr;
    logic [31:0]       w_rd_val;

    assign w_rd_idx   = bus.req_addr[ADDR_W-1:0];
    assign w_pci_idx  = bus.pci_req_addr[ADDR_W-1:0];
    assign w_req_hi   = (bus.req_addr >> ADDR_W) != 21'd0;
    assign w_pci_hi   = (bus.pci_req_addr >> ADDR_W) != 21'd0;
    assign w_run      = (state_q == S_RUN);
    assign w_host_own = (state_q == S_HOST) || (state_q == S_DONE);
    assign w_fpga_rd  = w_run & bus.rd_req;

`ifdef HOST_MEM_OOB_CHECK_EN
    logic oob_err_q, oob_err_d;
    logic w_oob_hit;

    // Out-of-range accesses are blocked but still complete as reads of zero.
    assign w_fpga_wr = w_run & bus.FPGA_wr_en & ~w_req_hi;
    assign w_pci_wr  = w_host_own & bus.pci_wr_en & ~w_pci_hi;
    assign w_rd_val  = w_req_hi ? 32'd0 : mem[w_rd_idx];
    assign w_oob_hit = (w_run & (bus.rd_req | bus.FPGA_wr_en) & w_req_hi)
                     | (w_host_own & bus.pci_wr_en & w_pci_hi);
    assign oob_err_d = (bus.pci_start ? 1'b0 : oob_err_q) | w_oob_hit;
    assign bus.oob_err = oob_err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) oob_err_q <= 1'b0;
        else        oob_err_q <= oob_err_d;
    end
`else
    logic w_unused_hi;

    assign w_fpga_wr   = w_run & bus.FPGA_wr_en;
    assign w_pci_wr    = w_host_own & bus.pci_wr_en;
    assign w_rd_val    = mem[w_rd_idx];
    assign w_unused_hi = w_req_hi ^ w_pci_hi;
`endif

    // No reset on the array: contents survive rst_n by design.
    always_ff @(posedge clk) begin
        if (w_fpga_wr)
            mem[w_rd_idx] <= bus.write_data;
        else if (w_pci_wr)
            mem[w_pci_idx] <= bus.pci_input_data;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_HOST:  if (bus.pci_start) state_d = S_START;
            S_START: state_d = S_RUN;
            S_RUN:   if (bus.flag_we && bus.out_flag[0]) state_d = S_DONE;
            S_DONE:  if (bus.pci_start || bus.pci_wr_en) state_d = S_HOST;
            default: state_d = S_HOST;
        endcase
    end

    assign rd_ready_d  = w_fpga_rd;
    assign rd_data_d   = w_fpga_rd ? w_rd_val : rd_data_q;
    assign fpga_flag_d = bus.flag_we ? bus.out_flag : fpga_flag_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_HOST;
            rd_ready_q  <= 1'b0;
            rd_data_q   <= 32'd0;
            fpga_flag_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            rd_ready_q  <= rd_ready_d;
            rd_data_q   <= rd_data_d;
            fpga_flag_q <= fpga_flag_d;
        end
    end

    assign bus.rd_data   = rd_data_q;
    assign bus.rd_ready  = rd_ready_q;
    assign bus.in_flag   = (state_q == S_START) ? (32'd1 << START_BIT) : 32'd0;
    assign bus.pci_ready = w_host_own;
    assign bus.done      = (state_q == S_DONE);
    assign bus.fpga_flag = fpga_flag_q;

endmodule
`default_nettype wire

// File: doc/host_mem_responder.md
HOST_MEM_RESPONDER -- requirements
Module: host_mem_responder

Interface
REQ-001 Parameter ADDR_W, default 12: log2 of internal word-memory depth (2**ADDR_W x 32 bits).
REQ-002 Parameter START_BIT, default 16: in_flag bit position that carries the start pulse.
REQ-003 clk  input  1  single clock; all logic is on the rising edge.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 rd_req  input  1  FPGA read request.
REQ-006 req_addr  input  21  FPGA word address for reads and writes.
REQ-007 FPGA_wr_en  input  1  FPGA write strobe.
REQ-008 write_data  input  32  FPGA write data.
REQ-009 flag_we  input  1  FPGA flag-register write strobe.
REQ-010 out_flag  input  32  FPGA flag value.
REQ-011 rd_data  output  32  read data returned to the FPGA.
REQ-012 rd_ready  output  1  rd_data valid.
REQ-013 in_flag  output  32  host-to-FPGA flag word.
REQ-014 pci_wr_en  input  1  host write strobe.
REQ-015 pci_req_addr  input  21  host word address.
REQ-016 pci_input_data  input  32  host write data.
REQ-017 pci_start  input  1  host start command (one cycle).
REQ-018 pci_ready  output  1  host write accepted this cycle.
REQ-019 done  output  1  FPGA reported completion.
REQ-020 fpga_flag  output  32  last out_flag value written by the FPGA.

Function
REQ-021 State machine: HOST, START, RUN, DONE.
- HOST: host owns memory; pci_ready=1; FPGA rd_req and FPGA_wr_en are ignored and rd_ready stays 0.
- HOST->START on pci_start=1.
- START: lasts exactly 1 cycle; in_flag[START_BIT]=1 for that cycle only; goes to RUN.
- RUN: FPGA owns memory; pci_ready=0; pci_wr_en is dropped, not queued.
- RUN->DONE on flag_we=1 with out_flag[0]=1.
- DONE: done=1 and pci_ready=1; goes to HOST on the next pci_start, or on a pci_wr_en write.
REQ-022 In RUN, rd_req at edge N samples req_addr[ADDR_W-1:0]; rd_data=mem[addr] and rd_ready=1 during cycle N+1 (1-cycle latency, back-to-back each cycle).
REQ-023 rd_ready is deasserted in every cycle following a cycle with no accepted read; rd_data holds its last value.
REQ-024 FPGA_wr_en in RUN writes write_data to mem[req_addr] at the edge.
REQ-025 rd_req and FPGA_wr_en to the same address in the same cycle return the old data (read-before-write).
REQ-026 pci_wr_en in HOST or DONE writes pci_input_data to mem[pci_req_addr]; pci_ready=1 that cycle.
REQ-027 flag_we in any state latches out_flag into fpga_flag.
REQ-028 in_flag bits other than START_BIT are 0.
REQ-029 pci_start while already in START, RUN or DONE-to-START has no effect.

Reset
REQ-030 rst_n=0 at an edge forces: state HOST, rd_ready=0, rd_data=0, in_flag=0, done=0, fpga_flag=0.
REQ-031 Memory contents are not cleared by reset.
REQ-032 Reset mid-RUN drops any outstanding read: rd_ready=0 on the next cycle.

Configuration
REQ-033 Macro HOST_MEM_OOB_CHECK_EN:
- Defined: an address with any bit set above ADDR_W-1 reads 0 (rd_ready still 1), is not written, and sets sticky output oob_err (1 bit, cleared by reset or pci_start).
- Undefined: upper address bits are ignored (addresses wrap modulo 2**ADDR_W) and oob_err does not exist.

Verification
REQ-034 Host writes 0x41434143 to addresses 1..64, pci_start, FPGA rd_req addr 5 -> rd_ready=1 and rd_data=0x41434143 one cycle later; in_flag=0x0001_0000 for exactly 1 cycle.
REQ-035 FPGA reads addresses 0..9 back-to-back -> rd_ready high 10 consecutive cycles, data in address order.
REQ-036 In RUN, FPGA_wr_en and rd_req both to addr 7 (old 0x11, new 0x22) -> read returns 0x11; a later read returns 0x22.
REQ-037 pci_wr_en during RUN -> pci_ready=0, memory unchanged; flag_we with out_flag=0x1 -> done=1, fpga_flag=0x1.
REQ-038 rst_n=0 while a read is outstanding -> rd_ready=0, state HOST, done=0.
REQ-039 With HOST_MEM_OOB_CHECK_EN and ADDR_W=12: read addr 0x1000 -> rd_data=0, oob_err=1; without the macro the same read returns mem[0].
